// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the shared ALU arbiter.
// Latency: none (wires only).
// Backpressure: rsp_ready from the consumer throttles both request channels via reqN_ready.
interface alu_share_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_sel;

  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_sel;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_overflow;

  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
    output grant_cnt0, grant_cnt1
  );

  // Requester / consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
    input  grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 4-bit add/sub unit between two requesters; optional ARB_GRANT_CNT_EN counters.
// Latency: result registered, rsp_valid high right after the accepting edge; one op per cycle.
// Backpressure: a held response (rsp_valid & ~rsp_ready) drops both readies; drain+accept same cycle.
module alu_share_arbiter (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  logic       last_grant;   // requester granted on the most recent transfer
  logic       can_accept;
  logic       grant0, grant1;
  logic       xfer0, xfer1, xfer;
  logic [3:0] op_a, op_b;
  logic       op_sel;
  logic [4:0] add_full, sub_full;
  logic [3:0] alu_result;
  logic       alu_carry, alu_overflow;

  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [3:0] rsp_result_q;
  logic       rsp_carry_q;
  logic       rsp_overflow_q;

  assign can_accept = ~rsp_valid_q | bus.rsp_ready;

  // Tie goes to the requester not granted last; a lone requester always wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  // rst_n gate keeps both readies low for the whole reset interval.
  assign bus.req0_ready = grant0 & can_accept & rst_n;
  assign bus.req1_ready = grant1 & can_accept & rst_n;
  assign xfer0 = bus.req0_valid & bus.req0_ready;
  assign xfer1 = bus.req1_valid & bus.req1_ready;
  assign xfer  = xfer0 | xfer1;

  // Operand mux and arithmetic on the granted requester's operands.
  always_comb begin
    op_a     = grant1 ? bus.req1_a   : bus.req0_a;
    op_b     = grant1 ? bus.req1_b   : bus.req0_b;
    op_sel   = grant1 ? bus.req1_sel : bus.req0_sel;
    add_full = {1'b0, op_a} + {1'b0, op_b};
    sub_full = {1'b0, op_a} - {1'b0, op_b};
    if (op_sel) begin
      alu_result   = sub_full[3:0];
      alu_carry    = sub_full[4];
      alu_overflow = sub_full[4];
    end else begin
      alu_result   = add_full[3:0];
      alu_carry    = add_full[4];
      alu_overflow = op_a[3] & op_b[3] & ~add_full[3];
    end
  end

  // One-deep response register; a new result takes priority over a plain drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= 4'd0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else if (xfer) begin
      rsp_valid_q    <= 1'b1;
      rsp_id_q       <= xfer1;
      rsp_result_q   <= alu_result;
      rsp_carry_q    <= alu_carry;
      rsp_overflow_q <= alu_overflow;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q    <= 1'b0;
    end
  end

  // Round-robin pointer moves only when an operation is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= xfer1;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_overflow = rsp_overflow_q;

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  // Per-requester accepted-operation counters, wrapping at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (xfer0) cnt0_q <= cnt0_q + 8'd1;
      if (xfer1) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;
`else
  assign bus.grant_cnt0 = 8'd0;
  assign bus.grant_cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises hold, drain+accept and async reset with a full response register.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARB_GRANT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input logic [7:0] v);
    return CNT_EN ? v : 8'd0;
  endfunction

  task automatic drive(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b, input bit sel);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
    end
  endtask

  // Issue a single op from one requester, check it is ready, then check the registered response.
  task automatic issue(input string tag, input bit id, input logic [3:0] a, input logic [3:0] b,
                       input bit sel, input logic [3:0] res, input bit cy, input bit ov);
    drive(id, 1'b1, a, b, sel);
    #1;
    chk({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 8'd1);
    @(posedge clk); #1;
    drive(id, 1'b0, 4'd0, 4'd0, 1'b0);
    chk({tag, "_valid"}, bus.rsp_valid, 8'd1);
    chk({tag, "_id"}, bus.rsp_id, {7'd0, id});
    chk({tag, "_result"}, bus.rsp_result, {4'd0, res});
    chk({tag, "_carry"}, bus.rsp_carry, {7'd0, cy});
    chk({tag, "_ovf"}, bus.rsp_overflow, {7'd0, ov});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);  // valid held during reset: ready must stay low
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    bus.rsp_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", bus.rsp_valid, 8'd0);
    chk("rst_id", bus.rsp_id, 8'd0);
    chk("rst_result", bus.rsp_result, 8'd0);
    chk("rst_carry", bus.rsp_carry, 8'd0);
    chk("rst_ovf", bus.rsp_overflow, 8'd0);
    chk("rst_ready0", bus.req0_ready, 8'd0);
    chk("rst_cnt0", bus.grant_cnt0, 8'd0);
    chk("rst_cnt1", bus.grant_cnt1, 8'd0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single operations through the ALU
    issue("add3p2",  1'b0, 4'd3,  4'd2, 1'b0, 4'd5,  1'b0, 1'b0);
    issue("sub5m6",  1'b1, 4'd5,  4'd6, 1'b1, 4'hF,  1'b1, 1'b1);
    issue("sub10m8", 1'b1, 4'd10, 4'd8, 1'b1, 4'd2,  1'b0, 1'b0);
    issue("add8p9",  1'b0, 4'd8,  4'd9, 1'b0, 4'd1,  1'b1, 1'b1);
    issue("add7p5",  1'b1, 4'd7,  4'd5, 1'b0, 4'd12, 1'b0, 1'b0);

    // No new request: response drains
    @(posedge clk); #1;
    chk("drain_valid", bus.rsp_valid, 8'd0);
    chk("drain_result_hold", bus.rsp_result, 8'd12);
    chk("pre_cnt0", bus.grant_cnt0, cnt_exp(8'd2));
    chk("pre_cnt1", bus.grant_cnt1, cnt_exp(8'd3));

    // Contention: last grant was req1, so req0 wins first and they alternate
    drive(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);  // 1+1 = 2
    drive(1'b1, 1'b1, 4'd4, 4'd1, 1'b1);  // 4-1 = 3
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_ready0", bus.req0_ready, (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("cont_ready1", bus.req1_ready, (i % 2 == 0) ? 8'd0 : 8'd1);
      @(posedge clk); #1;
      chk("cont_valid", bus.rsp_valid, 8'd1);
      chk("cont_id", bus.rsp_id, (i % 2 == 0) ? 8'd0 : 8'd1);
      chk("cont_result", bus.rsp_result, (i % 2 == 0) ? 8'd2 : 8'd3);
    end
    chk("cont_cnt0", bus.grant_cnt0, cnt_exp(8'd5));
    chk("cont_cnt1", bus.grant_cnt1, cnt_exp(8'd6));

    // Backpressure: full register blocks both requesters, contents hold
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready0", bus.req0_ready, 8'd0);
      chk("bp_ready1", bus.req1_ready, 8'd0);
      @(posedge clk); #1;
      chk("bp_valid", bus.rsp_valid, 8'd1);
      chk("bp_id", bus.rsp_id, 8'd1);
      chk("bp_result", bus.rsp_result, 8'd3);
    end
    chk("bp_cnt0", bus.grant_cnt0, cnt_exp(8'd5));
    chk("bp_cnt1", bus.grant_cnt1, cnt_exp(8'd6));

    // Release: drain and accept in the same cycle, no bubble
    bus.rsp_ready = 1'b1;
    #1;
    chk("rel_ready0", bus.req0_ready, 8'd1);
    chk("rel_ready1", bus.req1_ready, 8'd0);
    @(posedge clk); #1;
    chk("rel_valid", bus.rsp_valid, 8'd1);
    chk("rel_id", bus.rsp_id, 8'd0);
    chk("rel_result", bus.rsp_result, 8'd2);
    chk("rel_cnt0", bus.grant_cnt0, cnt_exp(8'd6));

    // Async reset mid-cycle with a pending response; last grant was req0
    bus.rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.rsp_valid, 8'd0);
    chk("arst_ready0", bus.req0_ready, 8'd0);
    chk("arst_ready1", bus.req1_ready, 8'd0);
    chk("arst_cnt0", bus.grant_cnt0, 8'd0);
    chk("arst_cnt1", bus.grant_cnt1, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready0", bus.req0_ready, 8'd1);
    chk("post_rst_ready1", bus.req1_ready, 8'd0);
    @(posedge clk); #1;
    chk("post_rst_id", bus.rsp_id, 8'd0);
    chk("post_rst_valid", bus.rsp_valid, 8'd1);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer sharing one 4-bit add/subtract arithmetic unit between two requesters. Each requester issues operations over a valid/ready channel. The block grants one operation per cycle, computes it combinationally through the arithmetic unit, and captures the outcome in a one-deep output register. Results are returned on a single tagged response channel with backpressure. It sits between the team's control logic and the arithmetic datapath.

## Interface
Parameters:
- none (widths fixed: 4-bit operands, 8-bit grant counters)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  4  requester 0 operands
- req0_sel  in  1  requester 0 op: 0 = add, 1 = subtract
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  as requester 0, for requester 1
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_id  out  1  requester that issued the result
- rsp_result  out  4  sum or difference
- rsp_carry  out  1  add: carry-out; subtract: borrow
- rsp_overflow  out  1  overflow flag, per arithmetic rules below
- grant_cnt0, grant_cnt1  out  8  accepted-operation counters (see Configuration)

## Operation
- Transfer on a request channel: reqN_valid & reqN_ready at a rising edge.
- Transfer on the response channel: rsp_valid & rsp_ready at a rising edge.
- can_accept = ~rsp_valid | rsp_ready.
- Arbitration (combinational):
  - With only one valid requester, that requester is granted.
  - With both valid, the requester not granted last is granted. The last-granted pointer updates only on an actual transfer.
  - After reset the pointer is 1, so requester 0 wins the first tie.
- reqN_ready = grant_N & can_accept. At most one ready is high per cycle. Ready may depend on valid.
- Arithmetic, 4-bit unsigned, computed on the granted operands:
  - Add: {carry, result} = A + B (5-bit); overflow = A[3] & B[3] & ~result[3].
  - Subtract: {borrow, result} = A − B, modulo 2^5 (borrow = 1 iff A < B); carry = overflow = borrow.
- Output register load:
  - On a request transfer it loads result, carry, overflow and id, and sets rsp_valid.
  - Otherwise, on a response transfer, it clears rsp_valid; data fields hold their values.
- Requesters must hold valid and operands stable until ready. The block does not check this.

## Timing
- Reset values (asynchronous, immediate on rst_n low): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_overflow=0, pointer=1, grant_cnt0=grant_cnt1=0. reqN_ready is 0 while in reset.
- Latency: an operation accepted at edge N has rsp_valid=1 with its result immediately after edge N.
- Throughput: one operation per cycle while rsp_ready=1. Two contending requesters alternate 0,1,0,1,…
- Full: rsp_valid=1 and rsp_ready=0 forces both ready signals to 0. The pointer and counters hold.
- Simultaneous drain and accept in the same cycle: the new result replaces the drained one and rsp_valid stays 1, with no bubble.
- Reset mid-operation: a pending response is discarded, and the pointer returns to 1.
- A requester that drops valid is never granted. The idle requester does not consume a round-robin turn.

## Configuration
- ARB_GRANT_CNT_EN defined:
  - grant_cnt0 and grant_cnt1 count request transfers per requester.
  - Counters are 8-bit and wrap from 255 to 0.
  - Counters clear only on reset.
- ARB_GRANT_CNT_EN undefined: no counter registers exist, and both outputs are tied to 8'd0.

## Test plan
- Single add: reset, then req0 issues A=3, B=2, sel=0 with rsp_ready=1 → next cycle rsp_valid=1, id=0, result=5, carry=0, overflow=0.
- Subtract with borrow: req1 issues A=5, B=6, sel=1 → result=4'b1111, carry=1, overflow=1, id=1. Also A=10, B=8, sel=1 → result=2, carry=0, overflow=0.
- Add overflow: A=8, B=9, sel=0 → result=1, carry=1, overflow=1. Also A=7, B=5 → result=12, carry=0, overflow=0.
- Contention: both valid continuously with rsp_ready=1 for 6 cycles → ids 0,1,0,1,0,1, one response per cycle. With ARB_GRANT_CNT_EN, both counters read 3.
- Backpressure: rsp_ready=0 for 3 cycles while both are valid → both ready=0 and the response holds stable. Raising rsp_ready gives drain plus accept in the same cycle with rsp_valid continuously 1.
- Async reset: assert rst_n=0 mid-cycle while rsp_valid=1 → rsp_valid drops immediately, and the first tie after release grants requester 0.
